// File: rtl/pmem_arbiter.sv
// Arbitrates one physical-memory line port between the I-cache and D-cache controllers.
// Optional ARB_ROUND_ROBIN_EN: alternate grants when both caches request in the same IDLE cycle.
module pmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_pmem_read,
   input  logic [ADDR_W-1:0] i_pmem_addr,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_addr,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_I = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;

   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

   logic [1:0] state_r;
   logic [1:0] next_state_s;
   logic       last_gnt_r;
   logic       next_last_gnt_s;
   logic       i_req_s;
   logic       d_req_s;

   assign i_req_s = i_pmem_read;
   assign d_req_s = d_pmem_read | d_pmem_write;

   // Next-state and last-grant selection
   always_comb begin
      next_state_s    = state_r;
      next_last_gnt_s = last_gnt_r;
      case (state_r)
         IDLE: begin
            if (i_req_s && d_req_s) begin
`ifdef ARB_ROUND_ROBIN_EN
               next_state_s = (last_gnt_r == LAST_D) ? GNT_I : GNT_D;
`else
               next_state_s = GNT_D;
`endif
            end else if (d_req_s) begin
               next_state_s = GNT_D;
            end else if (i_req_s) begin
               next_state_s = GNT_I;
            end else begin
               next_state_s = IDLE;
            end
         end
         GNT_I: begin
            // A completed transaction and an abort both return to IDLE; only completion updates history
            if (pmem_resp) begin
               next_state_s    = IDLE;
               next_last_gnt_s = LAST_I;
            end else if (!i_req_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = GNT_I;
            end
         end
         GNT_D: begin
            if (pmem_resp) begin
               next_state_s    = IDLE;
               next_last_gnt_s = LAST_D;
            end else if (!d_req_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = GNT_D;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State and grant-history registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         last_gnt_r <= LAST_I;
      end else begin
         state_r    <= next_state_s;
         last_gnt_r <= next_last_gnt_s;
      end
   end

   // Memory strobes and per-cache responses decoded from the current grant
   always_comb begin
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      i_pmem_resp = 1'b0;
      d_pmem_resp = 1'b0;
      case (state_r)
         GNT_I: begin
            pmem_read   = i_pmem_read;
            i_pmem_resp = pmem_resp;
         end
         GNT_D: begin
            // Simultaneous read and write from the D-cache is a write-back
            pmem_write  = d_pmem_write;
            pmem_read   = d_pmem_read & ~d_pmem_write;
            d_pmem_resp = pmem_resp;
         end
         default: begin
            pmem_read   = 1'b0;
            pmem_write  = 1'b0;
            i_pmem_resp = 1'b0;
            d_pmem_resp = 1'b0;
         end
      endcase
   end

   assign pmem_addr    = (state_r == GNT_I) ? i_pmem_addr : d_pmem_addr;
   assign pmem_wdata   = d_pmem_wdata;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: per-cycle comparison against an ownership model
// plus literal checks of strobe timing and the order in which memory served requests.
module tb_pmem_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_pmem_read;
   logic [15:0]   i_pmem_addr;
   logic [127:0]  i_pmem_rdata;
   logic          i_pmem_resp;
   logic          d_pmem_read;
   logic          d_pmem_write;
   logic [15:0]   d_pmem_addr;
   logic [127:0]  d_pmem_wdata;
   logic [127:0]  d_pmem_rdata;
   logic          d_pmem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [15:0]   pmem_addr;
   logic [127:0]  pmem_wdata;
   logic [127:0]  pmem_rdata;
   logic          pmem_resp;

   int total = 0;
   int passed = 0;

   pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_pmem_read(i_pmem_read), .i_pmem_addr(i_pmem_addr),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_addr(d_pmem_addr), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Ownership model: who (0 none, 1 I-cache, 2 D-cache) holds the memory port
   int m_owner = 0;
   int m_last = 1;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner <= 0;
         m_last  <= 1;
         m_valid <= 1'b1;
      end else if (m_owner == 0) begin
         if (i_pmem_read && (d_pmem_read || d_pmem_write)) begin
`ifdef ARB_ROUND_ROBIN_EN
            m_owner <= (m_last == 2) ? 1 : 2;
`else
            m_owner <= 2;
`endif
         end else if (d_pmem_read || d_pmem_write) m_owner <= 2;
         else if (i_pmem_read) m_owner <= 1;
      end else if (pmem_resp) begin
         m_last  <= m_owner;
         m_owner <= 0;
      end else if (m_owner == 1 && !i_pmem_read) m_owner <= 0;
      else if (m_owner == 2 && !(d_pmem_read || d_pmem_write)) m_owner <= 0;
   end

   // Served-transaction log taken from what memory completed
   int          log_who[$];
   logic [15:0] log_addr[$];
   logic        log_wr[$];

   always @(negedge clk) begin
      if (m_valid) begin
         check("i_resp", i_pmem_resp, pmem_resp && m_owner == 1);
         check("d_resp", d_pmem_resp, pmem_resp && m_owner == 2);
         check("i_rdata", i_pmem_rdata, pmem_rdata);
         check("d_rdata", d_pmem_rdata, pmem_rdata);
         check("pmem_read", pmem_read,
               (m_owner == 1) ? i_pmem_read : (m_owner == 2) ? (d_pmem_read && !d_pmem_write) : 1'b0);
         check("pmem_write", pmem_write, (m_owner == 2) && d_pmem_write);
         check("pmem_addr", pmem_addr, (m_owner == 1) ? i_pmem_addr : d_pmem_addr);
         check("pmem_wdata", pmem_wdata, d_pmem_wdata);
         if (pmem_resp && (i_pmem_resp || d_pmem_resp)) begin
            log_who.push_back(i_pmem_resp ? 1 : 2);
            log_addr.push_back(pmem_addr);
            log_wr.push_back(pmem_write);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for a strobe, hold for lat cycles total, then raise pmem_resp this cycle
   task automatic mem_resp(input int lat, input logic [127:0] data);
      for (int k = 0; k < 10 && !(pmem_read || pmem_write); k++) tick();
      check("strobe_wait", pmem_read || pmem_write, 1'b1);
      repeat (lat - 1) tick();
      pmem_rdata = data;
      pmem_resp  = 1'b1;
      #1;
   endtask

   // Complete the response cycle; the served cache drops its request as a controller would
   task automatic retire();
      int own;
      own = m_owner;
      tick();
      pmem_resp = 1'b0;
      if (own == 1) i_pmem_read = 1'b0;
      if (own == 2) begin
         d_pmem_read  = 1'b0;
         d_pmem_write = 1'b0;
      end
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          exp_who[7];
      logic [15:0] exp_addr[7];
      logic        exp_wr[7];

      rst_n = 1'b0; i_pmem_read = 1'b1; i_pmem_addr = 16'h0000;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = 16'h0000;
      d_pmem_wdata = 128'h0; pmem_rdata = 128'h0; pmem_resp = 1'b0;

      // 1: reset holds outputs low despite a pending I request
      tick(); tick();
      check("rst_pmem_read", pmem_read, 1'b0);
      check("rst_i_resp", i_pmem_resp, 1'b0);
      rst_n = 1'b1; i_pmem_read = 1'b0;
      tick();

      // 2: lone I read
      i_pmem_read = 1'b1; i_pmem_addr = 16'h1230;
      check("t2_cycle1_read", pmem_read, 1'b0);
      tick();
      check("t2_read", pmem_read, 1'b1);
      check("t2_addr", pmem_addr, 16'h1230);
      mem_resp(3, {16{8'hA5}});
      check("t2_i_resp", i_pmem_resp, 1'b1);
      check("t2_rdata", i_pmem_rdata, {16{8'hA5}});
      check("t2_d_resp", d_pmem_resp, 1'b0);
      retire();
      check("t2_turnaround", pmem_read, 1'b0);

      // 3: simultaneous I read and D write
      i_pmem_read = 1'b1; i_pmem_addr = 16'h0040;
      d_pmem_write = 1'b1; d_pmem_addr = 16'h8000; d_pmem_wdata = 128'h1;
      tick();
      check("t3_write", pmem_write, 1'b1);
      check("t3_wdata", pmem_wdata, 128'h1);
      check("t3_waddr", pmem_addr, 16'h8000);
      mem_resp(2, 128'h0);
      retire();
      check("t3_idle_read", pmem_read, 1'b0);
      check("t3_idle_write", pmem_write, 1'b0);
      tick();
      check("t3_i_read", pmem_read, 1'b1);
      check("t3_i_addr", pmem_addr, 16'h0040);
      mem_resp(1, 128'h2);
      retire();

      // 4: write-back then allocate with an I fetch waiting
      i_pmem_read = 1'b1; i_pmem_addr = 16'h1000;
      d_pmem_write = 1'b1; d_pmem_addr = 16'h8000; d_pmem_wdata = 128'h3;
      mem_resp(2, 128'h0);
      retire();
      d_pmem_read = 1'b1; d_pmem_addr = 16'h9000;
      mem_resp(2, 128'h4);
      retire();
      mem_resp(2, 128'h5);
      retire();

      // 5: stray response in IDLE
      pmem_resp = 1'b1; #1;
      check("t5_i_resp", i_pmem_resp, 1'b0);
      check("t5_d_resp", d_pmem_resp, 1'b0);
      tick();
      pmem_resp = 1'b0; #1;
      check("t5_idle", pmem_read || pmem_write, 1'b0);

      // Reset mid-transaction, then a late response is ignored
      d_pmem_read = 1'b1; d_pmem_addr = 16'h2000;
      tick();
      check("rm_granted", pmem_read, 1'b1);
      rst_n = 1'b0; d_pmem_read = 1'b0;
      tick();
      rst_n = 1'b1; pmem_resp = 1'b1; #1;
      check("rm_d_resp", d_pmem_resp, 1'b0);
      tick();
      pmem_resp = 1'b0;

      // 6: abort in GNT_I, pending D request granted afterwards
      i_pmem_read = 1'b1; i_pmem_addr = 16'h3000;
      tick();
      check("t6_i_read", pmem_read, 1'b1);
      d_pmem_read = 1'b1; d_pmem_addr = 16'h4000;
      tick();
      check("t6_still_i", pmem_addr, 16'h3000);
      i_pmem_read = 1'b0;
      tick();
      check("t6_abort_read", pmem_read, 1'b0);
      check("t6_abort_resp", i_pmem_resp, 1'b0);
      tick();
      check("t6_d_read", pmem_read, 1'b1);
      check("t6_d_addr", pmem_addr, 16'h4000);
      mem_resp(1, 128'h6);
      check("t6_d_resp", d_pmem_resp, 1'b1);
      retire();
      tick();

      exp_who[0] = 1; exp_addr[0] = 16'h1230; exp_wr[0] = 1'b0;
      exp_who[1] = 2; exp_addr[1] = 16'h8000; exp_wr[1] = 1'b1;
      exp_who[2] = 1; exp_addr[2] = 16'h0040; exp_wr[2] = 1'b0;
      exp_who[3] = 2; exp_addr[3] = 16'h8000; exp_wr[3] = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_who[4] = 1; exp_addr[4] = 16'h1000; exp_wr[4] = 1'b0;
      exp_who[5] = 2; exp_addr[5] = 16'h9000; exp_wr[5] = 1'b0;
`else
      exp_who[4] = 2; exp_addr[4] = 16'h9000; exp_wr[4] = 1'b0;
      exp_who[5] = 1; exp_addr[5] = 16'h1000; exp_wr[5] = 1'b0;
`endif
      exp_who[6] = 2; exp_addr[6] = 16'h4000; exp_wr[6] = 1'b0;

      check("log_len", log_who.size(), 7);
      for (int n = 0; n < 7; n++) begin
         if (n < log_who.size()) begin
            check($sformatf("log_who%0d", n), log_who[n], exp_who[n]);
            check($sformatf("log_addr%0d", n), log_addr[n], exp_addr[n]);
            check($sformatf("log_wr%0d", n), log_wr[n], exp_wr[n]);
         end else begin
            check($sformatf("log_missing%0d", n), 0, 1);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
